// File: rtl/sc_fifo_gen.sv
// Single-clock FIFO with show-ahead (FWFT) or registered-read output, selected by SHOW_AHEAD.
// Define SC_FIFO_GEN_CLR_EN to add a synchronous clr input that flushes the FIFO.
module sc_fifo_gen #(
    parameter int DW         = 8,
    parameter int AW         = 4,
    parameter int SHOW_AHEAD = 1,
    parameter int AF_TH      = (2**AW) - 2,
    parameter int AE_TH      = 1
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef SC_FIFO_GEN_CLR_EN
    input  logic          clr,
`endif
    input  logic [DW-1:0] din,
    input  logic          write,
    input  logic          read,
    output logic [DW-1:0] dout,
    output logic [AW:0]   data_cnt,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          wr_err,
    output logic          rd_err
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0] C_AF    = AF_TH[AW:0];
    localparam logic [AW:0] C_AE    = AE_TH[AW:0];
    localparam logic [AW:0] C_ONE   = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic [DW-1:0] r_q;
    logic          r_wr_err;
    logic          r_rd_err;

    logic w_clr;
    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_ram_req;
    logic w_ram_re;

`ifdef SC_FIFO_GEN_CLR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    assign w_full   = (r_cnt == C_DEPTH);
    assign w_wr_acc = write && !w_full && !w_clr;
    assign w_rd_acc = read && !w_empty && !w_clr;
    assign w_ram_re = w_ram_req && !w_clr;

    generate
        if (SHOW_AHEAD != 0) begin : g_fwft
            // r_qv marks that r_q holds the head word; the RAM holds the rest.
            logic r_qv;
            logic w_ram_has;

            assign w_ram_has = (r_rd_ptr != r_wr_ptr);
            assign w_ram_req = w_ram_has && (!r_qv || read);
            assign w_empty   = !r_qv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_qv <= 1'b0;
                end else if (w_clr) begin
                    r_qv <= 1'b0;
                end else if (w_ram_has) begin
                    r_qv <= 1'b1;
                end else if (read) begin
                    r_qv <= 1'b0;
                end
            end
        end else begin : g_norm
            assign w_ram_req = w_rd_acc;
            assign w_empty   = (r_cnt == '0);
        end
    endgenerate

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_q      <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_ONE;
            end
            if (w_ram_re) begin
                r_rd_ptr <= r_rd_ptr + C_ONE;
                r_q      <= r_mem[r_rd_ptr[AW-1:0]];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + C_ONE;
                2'b01:   r_cnt <= r_cnt - C_ONE;
                default: r_cnt <= r_cnt;
            endcase
            r_wr_err <= write && w_full;
            r_rd_err <= read && w_empty;
        end
    end

    assign dout         = r_q;
    assign data_cnt     = r_cnt;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_cnt >= C_AF);
    assign almost_empty = (r_cnt <= C_AE);
    assign wr_err       = r_wr_err;
    assign rd_err       = r_rd_err;

endmodule

// File: tb/tb_sc_fifo_gen.sv
// Randomized bench: one FWFT and one normal-mode FIFO (DEPTH=4) driven in parallel,
// each checked against a queue-based reference model.
module tb_sc_fifo_gen;

    logic       clk;
    logic       rst_n;
    logic       clr_in;
    logic [7:0] din;
    logic       write;
    logic       read;

    logic [7:0] f_dout, n_dout;
    logic [2:0] f_cnt, n_cnt;
    logic       f_full, f_empty, f_af, f_ae, f_wr_err, f_rd_err;
    logic       n_full, n_empty, n_af, n_ae, n_wr_err, n_rd_err;

    int n_tests;
    int n_fail;

    sc_fifo_gen #(.DW(8), .AW(2), .SHOW_AHEAD(1), .AF_TH(3), .AE_TH(1)) u_fwft (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef SC_FIFO_GEN_CLR_EN
        .clr          (clr_in),
`endif
        .din          (din),
        .write        (write),
        .read         (read),
        .dout         (f_dout),
        .data_cnt     (f_cnt),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .wr_err       (f_wr_err),
        .rd_err       (f_rd_err)
    );

    sc_fifo_gen #(.DW(8), .AW(2), .SHOW_AHEAD(0), .AF_TH(3), .AE_TH(1)) u_norm (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef SC_FIFO_GEN_CLR_EN
        .clr          (clr_in),
`endif
        .din          (din),
        .write        (write),
        .read         (read),
        .dout         (n_dout),
        .data_cnt     (n_cnt),
        .full         (n_full),
        .empty        (n_empty),
        .almost_full  (n_af),
        .almost_empty (n_ae),
        .wr_err       (n_wr_err),
        .rd_err       (n_rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] fq[$];
    int         fwt[$];
    logic [7:0] f_dout_exp;
    bit         f_vis;
    bit         f_wr_err_exp, f_rd_err_exp;
    logic [7:0] nq[$];
    logic [7:0] n_dout_exp;
    bit         n_wr_err_exp, n_rd_err_exp;
    int         ne;
    int         cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        check_val("f_dout",   32'(f_dout),   32'(f_dout_exp));
        check_val("f_empty",  32'(f_empty),  32'(!f_vis));
        check_val("f_cnt",    32'(f_cnt),    32'(fq.size()));
        check_val("f_full",   32'(f_full),   32'(fq.size() == 4));
        check_val("f_af",     32'(f_af),     32'(fq.size() >= 3));
        check_val("f_ae",     32'(f_ae),     32'(fq.size() <= 1));
        check_val("f_wr_err", 32'(f_wr_err), 32'(f_wr_err_exp));
        check_val("f_rd_err", 32'(f_rd_err), 32'(f_rd_err_exp));
        check_val("n_dout",   32'(n_dout),   32'(n_dout_exp));
        check_val("n_empty",  32'(n_empty),  32'(nq.size() == 0));
        check_val("n_cnt",    32'(n_cnt),    32'(nq.size()));
        check_val("n_full",   32'(n_full),   32'(nq.size() == 4));
        check_val("n_af",     32'(n_af),     32'(nq.size() >= 3));
        check_val("n_ae",     32'(n_ae),     32'(nq.size() <= 1));
        check_val("n_wr_err", 32'(n_wr_err), 32'(n_wr_err_exp));
        check_val("n_rd_err", 32'(n_rd_err), 32'(n_rd_err_exp));
    endtask

    task automatic clear_model();
        fq.delete();
        fwt.delete();
        nq.delete();
        f_vis        = 1'b0;
        f_wr_err_exp = 1'b0;
        f_rd_err_exp = 1'b0;
        n_wr_err_exp = 1'b0;
        n_rd_err_exp = 1'b0;
    endtask

    // One clock: drive, let the edge happen, update models, compare 1 time unit later.
    task automatic cycle(input bit w, input bit r, input logic [7:0] d);
        bit f_full_pre, f_empty_pre, n_full_pre, n_empty_pre;
        write = w;
        read  = r;
        din   = d;
        f_full_pre  = (fq.size() == 4);
        f_empty_pre = !f_vis;
        n_full_pre  = (nq.size() == 4);
        n_empty_pre = (nq.size() == 0);
        @(posedge clk);
        ne++;
        cyc++;
        if (clr_in) begin
            clear_model();
        end else begin
            f_wr_err_exp = w && f_full_pre;
            f_rd_err_exp = r && f_empty_pre;
            if (r && !f_empty_pre) begin
                void'(fq.pop_front());
                void'(fwt.pop_front());
            end
            if (w && !f_full_pre) begin
                fq.push_back(d);
                fwt.push_back(ne);
            end
            // The head word reaches the output one edge after the edge that wrote it.
            f_vis = 1'b0;
            if (fq.size() > 0) begin
                if (fwt[0] <= ne - 1) f_vis = 1'b1;
            end
            if (f_vis) f_dout_exp = fq[0];

            n_wr_err_exp = w && n_full_pre;
            n_rd_err_exp = r && n_empty_pre;
            if (r && !n_empty_pre) n_dout_exp = nq.pop_front();
            if (w && !n_full_pre) nq.push_back(d);
        end
        #1;
        $display("[TB] cyc %0d clr=%0b w=%0b r=%0b d=%02h | fwft cnt=%0d empty=%0b dout=%02h | norm cnt=%0d empty=%0b dout=%02h",
                 cyc, clr_in, w, r, d, f_cnt, f_empty, f_dout, n_cnt, n_empty, n_dout);
        check_all();
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        #1;
        clear_model();
        f_dout_exp = 8'h00;
        n_dout_exp = 8'h00;
        $display("[TB] reset asserted at cyc %0d", cyc);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int wp;
        int rp;
        n_tests = 0;
        n_fail  = 0;
        ne      = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        clr_in  = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        din     = 8'h00;
        f_dout_exp = 8'h00;
        n_dout_exp = 8'h00;
        clear_model();
        #3;
        do_reset();

        // Single word latency, then read back
        cycle(1'b1, 1'b0, 8'hA5);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // Fill then stream out with read held high
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);

        // Overflow: fifth write rejected, extra reads underflow
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'h00);

        // Simultaneous write+read on empty FIFO
        cycle(1'b1, 1'b1, 8'h3C);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);

        // Hold occupancy at 3 through pointer wrap
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 8'(8'h50 + i));
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00);

        // Random traffic with varying write/read pressure
        for (int ph = 0; ph < 20; ph++) begin
            wp = int'($urandom_range(0, 4));
            rp = int'($urandom_range(0, 4));
            for (int i = 0; i < 100; i++) begin
                cycle(int'($urandom_range(0, 3)) < wp, int'($urandom_range(0, 3)) < rp,
                      8'($urandom_range(0, 255)));
            end
        end

        // Reset mid-stream with two entries held
        do_reset();
        cycle(1'b1, 1'b0, 8'h77);
        cycle(1'b1, 1'b0, 8'h88);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);

`ifdef SC_FIFO_GEN_CLR_EN
        // Synchronous clear wins over a same-cycle write on a full FIFO
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h90 + i));
        cycle(1'b0, 1'b0, 8'h00);
        clr_in = 1'b1;
        cycle(1'b1, 1'b1, 8'hEE);
        clr_in = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 8'h5A);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
